// File: rtl/inst_sram_fetch_pkg.sv
// Shared types and encodings for the instruction-side SRAM fetch unit.
package inst_sram_fetch_pkg;

  typedef enum logic [1:0] {
    IfIdle    = 2'd0,
    IfWaitBus = 2'd1,
    IfAccess  = 2'd2
  } if_state_e;

  localparam int SramAddrBus = 20;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam inst_t ZeroWord   = 32'h0000_0000;
  localparam logic  ChipEnable = 1'b1;

endpackage

// File: rtl/inst_sram_fetch.sv
// Fetch responder: multi-cycle base-SRAM read behind a one-entry hit register.
// Miss costs WAIT_CYCLES+2 stalled cycles (+1 per bus-busy cycle); hits return combinationally.
module inst_sram_fetch
  import inst_sram_fetch_pkg::*;
#(
  parameter int ADDR_W      = SramAddrBus,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       pc_i,
  input  logic              flush_i,
  input  logic              bus_busy_i,
  output logic [31:0]       inst_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  input  logic [31:0]       sram_data_i
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  if_state_e         state, state_nxt;
  inst_addr_t        req_pc, req_pc_nxt;
  inst_addr_t        hit_pc, hit_pc_nxt;
  logic              hit_valid, hit_valid_nxt;
  inst_t             inst_q, inst_q_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] sram_addr_q;
  logic              sram_en_q;

  logic aligned, hit, addr_change;

  assign aligned     = (pc_i[1:0] == 2'b00);
  assign hit         = (ce_i == ChipEnable) && hit_valid && (pc_i == hit_pc);
  assign addr_change = (pc_i != req_pc);

  always_comb begin
    state_nxt     = state;
    req_pc_nxt    = req_pc;
    hit_pc_nxt    = hit_pc;
    hit_valid_nxt = hit_valid;
    inst_q_nxt    = inst_q;
    cnt_nxt       = cnt;
    stallreq_o    = 1'b0;
    inst_o        = ZeroWord;

    if (rst) begin
      state_nxt = IfIdle;
    end else if (flush_i) begin
      state_nxt     = IfIdle;
      hit_valid_nxt = 1'b0;
    end else if (ce_i != ChipEnable) begin
      state_nxt     = IfIdle;
      hit_valid_nxt = 1'b0;
    end else if (!aligned) begin
      // Misaligned PC traps downstream; keep the hit entry, start nothing.
      state_nxt = IfIdle;
    end else begin
      case (state)
        IfIdle: begin
          if (hit) begin
            inst_o = inst_q;
          end else begin
            stallreq_o = 1'b1;
            req_pc_nxt = pc_i;
            if (bus_busy_i) begin
              state_nxt = IfWaitBus;
            end else begin
              state_nxt = IfAccess;
              cnt_nxt   = WaitLoad;
            end
          end
        end
        IfWaitBus: begin
          stallreq_o = 1'b1;
          if (addr_change) begin
            req_pc_nxt    = pc_i;
            hit_valid_nxt = 1'b0;
            cnt_nxt       = WaitLoad;
            state_nxt     = IfAccess;
          end else if (!bus_busy_i) begin
            cnt_nxt   = WaitLoad;
            state_nxt = IfAccess;
          end
        end
        IfAccess: begin
          stallreq_o = 1'b1;
          // A moved PC wins over a completing read so stale data is never captured.
          if (addr_change) begin
            req_pc_nxt    = pc_i;
            hit_valid_nxt = 1'b0;
            cnt_nxt       = WaitLoad;
          end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            inst_q_nxt    = sram_data_i;
            hit_pc_nxt    = req_pc;
            hit_valid_nxt = 1'b1;
            state_nxt     = IfIdle;
          end
        end
        default: state_nxt = IfIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IfIdle;
      req_pc      <= ZeroWord;
      hit_pc      <= ZeroWord;
      hit_valid   <= 1'b0;
      inst_q      <= ZeroWord;
      cnt         <= 4'd0;
      sram_addr_q <= '0;
      sram_en_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_pc    <= req_pc_nxt;
      hit_pc    <= hit_pc_nxt;
      hit_valid <= hit_valid_nxt;
      inst_q    <= inst_q_nxt;
      cnt       <= cnt_nxt;
      // Strobes and address are registered from the next state so they only move on edges.
      sram_en_q <= (state_nxt == IfAccess);
      if (state_nxt == IfAccess) begin
        sram_addr_q <= req_pc_nxt[ADDR_W+1:2];
      end
    end
  end

  assign sram_addr_o = sram_addr_q;
  assign sram_ce_n_o = ~sram_en_q;
  assign sram_oe_n_o = ~sram_en_q;
  assign sram_we_n_o = 1'b1;
  assign sram_be_n_o = 4'b0000;

endmodule

// File: tb/tb_inst_sram_fetch.sv
// Randomized self-checking bench for inst_sram_fetch against a hit-register/latency model.
module tb_inst_sram_fetch;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, ce, flush, busy;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          stall;
  logic [AW-1:0] saddr;
  logic          ce_n, oe_n, we_n;
  logic [3:0]    be_n;
  logic [31:0]   sdata;

  logic [31:0] mem [0:255];
  assign sdata = mem[saddr[7:0]];

  always #5 clk = ~clk;

  inst_sram_fetch #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .pc_i(pc), .flush_i(flush), .bus_busy_i(busy),
    .inst_o(inst), .stallreq_o(stall), .sram_addr_o(saddr), .sram_ce_n_o(ce_n),
    .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_be_n_o(be_n), .sram_data_i(sdata)
  );

  int checks = 0;
  int errors = 0;

  // Model: one remembered PC; a miss costs busy + W + 2 stalled cycles with W+1 strobe cycles.
  logic [31:0] model_pc = 32'h0;
  bit          model_valid = 1'b0;

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return AW'(a >> 2);
  endfunction

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    logic [AW-1:0] w;
    w = word_of(a);
    return mem[w[7:0]];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc_in, input int b, input int extra_strobes, input string name);
    bit exp_hit;
    int exp_stall, exp_str, stall_cnt, str_cnt, cyc;
    bit addr_ok, done;
    exp_hit   = model_valid && (pc_in == model_pc);
    exp_stall = exp_hit ? 0 : b + W + 2;
    exp_str   = exp_hit ? 0 : W + 1 + extra_strobes;
    stall_cnt = 0; str_cnt = 0; cyc = 0; addr_ok = 1'b1; done = 1'b0;
    pc = pc_in; ce = 1'b1; flush = 1'b0; busy = (b > 0);
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (ce_n === 1'b0) begin
        str_cnt++;
        if (cyc > 0 && saddr !== word_of(pc_in)) addr_ok = 1'b0;
      end
      if (stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      if (!done) begin
        next_cycle();
        cyc++;
        busy = (cyc < b);
      end
    end
    busy = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: stall still high after %0d cycles, required release after %0d", name, cyc, exp_stall);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++;
      $display("FAIL %s stall_len: got %0d cycles, expected %0d (pc=%h busy=%0d)", name, stall_cnt, exp_stall, pc_in, b);
    end
    checks++;
    if (str_cnt != exp_str) begin
      errors++;
      $display("FAIL %s strobe_cycles: got %0d, expected %0d (pc=%h)", name, str_cnt, exp_str, pc_in);
    end
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL %s sram_addr: saw wrong address during access, expected %h", name, word_of(pc_in));
    end
    checks++;
    if (inst !== mem_at(pc_in)) begin
      errors++;
      $display("FAIL %s inst: got %h, expected %h (pc=%h)", name, inst, mem_at(pc_in), pc_in);
    end
    model_pc    = pc_in;
    model_valid = 1'b1;
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (stall !== 1'b0 || inst !== 32'h0 || saddr !== '0 || ce_n !== 1'b1 || oe_n !== 1'b1 ||
        we_n !== 1'b1 || be_n !== 4'b0000) begin
      errors++;
      $display("FAIL %s: stall=%b inst=%h addr=%h ce_n=%b oe_n=%b we_n=%b be_n=%b, expected 0/0/0/1/1/1/0000",
               name, stall, inst, saddr, ce_n, oe_n, we_n, be_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; pc = 32'hbfc00000; flush = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    next_cycle();
    rst = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic test_first_fill();
    do_fetch(32'hbfc00000, 0, 0, "first_fill");
  endtask

  task automatic test_hit_hold();
    for (int i = 0; i < 3; i++) do_fetch(32'hbfc00000, 0, 0, "hit_hold");
  endtask

  task automatic test_next_word();
    do_fetch(32'hbfc00004, 0, 0, "next_word");
  endtask

  task automatic test_bus_busy();
    do_fetch(32'hbfc00008, 3, 0, "bus_busy");
  endtask

  task automatic test_flush();
    pc = 32'hbfc0001c; ce = 1'b1; busy = 1'b0; flush = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++;
    if (ce_n !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: ce_n=%b in first access cycle, expected 0", ce_n);
    end
    next_cycle();
    flush = 1'b1; pc = 32'hbfc00380;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b inst=%h, expected 0 and 0", stall, inst);
    end
    next_cycle();
    flush = 1'b0;
    model_valid = 1'b0;
    do_fetch(32'hbfc00380, 0, 0, "after_flush");
  endtask

  task automatic test_restart();
    pc = 32'hbfc00010; ce = 1'b1; busy = 1'b0; flush = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    model_valid = 1'b0;
    do_fetch(32'hbfc00014, 0, 1, "restart");
  endtask

  task automatic test_misaligned();
    logic [31:0] keep;
    keep = model_pc;
    pc = 32'hbfc00002; ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || inst !== 32'h0 || ce_n !== 1'b1) begin
        errors++;
        $display("FAIL misaligned: stall=%b inst=%h ce_n=%b, expected 0/0/1", stall, inst, ce_n);
      end
      next_cycle();
    end
    do_fetch(keep, 0, 0, "after_misaligned");
  endtask

  task automatic test_ce_low();
    logic [31:0] keep;
    keep = model_pc;
    ce = 1'b0; pc = keep;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL ce_low: stall=%b inst=%h, expected 0 and 0", stall, inst);
    end
    next_cycle();
    model_valid = 1'b0;
    do_fetch(keep, 0, 0, "after_ce_low");
  endtask

  task automatic test_reset_mid_access();
    pc = 32'hbfc00018; ce = 1'b1; busy = 1'b0; flush = 1'b0;
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_access");
    next_cycle();
    rst = 1'b0;
    model_valid = 1'b0;
    do_fetch(32'hbfc00018, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] p;
    int b;
    for (int i = 0; i < 24; i++) begin
      p = 32'hbfc00000 + (32'($urandom_range(0, 5)) << 2);
      b = $urandom_range(0, 3);
      do_fetch(p, b, 0, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h3c011234;
    test_reset();
    test_first_fill();
    test_hit_hold();
    test_next_word();
    test_bus_busy();
    test_flush();
    test_restart();
    test_misaligned();
    test_ce_low();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
